trafficchk_axis_sink: RTL

- AXI4-Stream receiver/checker: the consuming end of the traffic generator's M_AXIS stream.
- Accepts beats, checks the incrementing-data pattern and the tlast position against a programmed packet length, and counts beats, packets and errors.
- Configured and read back over a 4-register AXI4-Lite slave on the same clock.
- Sits in the block design as the loopback sink for generator bring-up and throughput tests.

---
 rtl/trafficchk_axis_sink.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/trafficchk_axis_sink.sv
// AXI4-Stream sink that checks an incrementing data pattern and tlast position, with AXI4-Lite control/status.
// Optional `TRAFFICCHK_THROTTLE_EN` drops tready one cycle in four while active.
module trafficchk_axis_sink #(
  parameter int C_S00_AXI_DATA_WIDTH   = 32,
  parameter int C_S00_AXI_ADDR_WIDTH   = 4,
  parameter int C_S00_AXIS_TDATA_WIDTH = 32
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_aresetn,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                                s00_axis_tvalid,
  input  logic                                s00_axis_tlast,
  output logic                                s00_axis_tready,
  output logic                                chk_error
);

  localparam int DATA_W = C_S00_AXIS_TDATA_WIDTH;

  typedef enum logic {DISABLED = 1'b0, ACTIVE = 1'b1} state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] cur, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++)
      if (strb[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_t              state, state_nxt;
  logic                awready_q, arready_q, bvalid_q, rvalid_q;
  logic [31:0]         rdata_q, rd_mux;
  logic                enable;
  logic [31:0]         len_reg;
  logic [2:0]          flags;
  logic [15:0]         err_count, pkt_count;
  logic [31:0]         beat_count, beat_idx;
  logic [DATA_W-1:0]   exp_data;
  logic                tready_q, tready_d, tready_out, chk_error_p1;
  logic                wr_en, rd_en, clear, beat;
  logic                data_bad, early_last, missing_last;
  logic [1:0]          err_inc;
  logic                unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  assign wr_en = awready_q & s00_axi_awvalid & s00_axi_wvalid;
  assign rd_en = arready_q & s00_axi_arvalid;
  assign clear = wr_en && (s00_axi_awaddr[3:2] == 2'd0) && s00_axi_wstrb[0] && s00_axi_wdata[1];

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = awready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = 2'b00;
  assign chk_error       = chk_error_p1;

  // AXI-Lite handshakes: ready pulses are one cycle wide because they self-cancel
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      awready_q <= ~awready_q & s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q;
      if (wr_en)               bvalid_q <= 1'b1;
      else if (s00_axi_bready) bvalid_q <= 1'b0;
      arready_q <= ~arready_q & s00_axi_arvalid & ~rvalid_q;
      if (rd_en) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      enable  <= 1'b0;
      len_reg <= '0;
    end else if (wr_en) begin
      case (s00_axi_awaddr[3:2])
        2'd0:    if (s00_axi_wstrb[0]) enable <= s00_axi_wdata[0];
        2'd1:    len_reg <= apply_strb(len_reg, s00_axi_wdata, s00_axi_wstrb);
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    case (s00_axi_araddr[3:2])
      2'd0: rd_mux = {27'd0, flags, 1'b0, enable};
      2'd1: rd_mux = len_reg;
      2'd2: rd_mux = {err_count, pkt_count};
      2'd3: rd_mux = beat_count;
    endcase
  end

  // Stream FSM; tready is registered so it trails the state by one cycle
  always_comb begin
    state_nxt = state;
    tready_d  = 1'b0;
    case (state)
      DISABLED: if (enable) state_nxt = ACTIVE;
      ACTIVE: begin
        tready_d = enable;
        if (!enable) state_nxt = DISABLED;
      end
      default: state_nxt = DISABLED;
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state    <= DISABLED;
      tready_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      tready_q <= tready_d;
    end
  end

`ifdef TRAFFICCHK_THROTTLE_EN
  logic [1:0] thr_cnt;
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) thr_cnt <= 2'd0;
    else                  thr_cnt <= thr_cnt + 2'd1;
  end
  assign tready_out = tready_q & (thr_cnt != 2'd3);
`else
  assign tready_out = tready_q;
`endif

  assign s00_axis_tready = tready_out;
  assign beat            = s00_axis_tvalid & tready_out;

  // Per-beat checks: data mismatch and tlast position relative to LEN
  assign data_bad     = (s00_axis_tdata != exp_data);
  assign early_last   = (len_reg != 0) && s00_axis_tlast && (beat_idx < len_reg - 32'd1);
  assign missing_last = (len_reg != 0) && !s00_axis_tlast && (beat_idx == len_reg - 32'd1);
  assign err_inc      = {1'b0, data_bad} + {1'b0, early_last} + {1'b0, missing_last};

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn || clear) begin
      flags      <= '0;
      err_count  <= '0;
      pkt_count  <= '0;
      beat_count <= '0;
      beat_idx   <= '0;
      exp_data   <= '0;
    end else if (beat) begin
      beat_count <= beat_count + 32'd1;
      exp_data   <= s00_axis_tdata + 1'b1;
      flags      <= flags | {missing_last, early_last, data_bad};
      err_count  <= sat_add16(err_count, err_inc);
      if (s00_axis_tlast) begin
        beat_idx  <= '0;
        pkt_count <= pkt_count + 16'd1;
      end else begin
        beat_idx  <= beat_idx + 32'd1;
      end
    end
  end

  // Error output registered one cycle behind the sticky flags
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) chk_error_p1 <= 1'b0;
    else                  chk_error_p1 <= |flags;
  end

endmodule
